// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, flit layout and injector FSM states.
package noc_pkg;

    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef struct packed {
        logic [1:0]  ftype;
        logic [29:0] payload;
    } flit_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } inj_state_e;

    // Tail and single-flit types both close a packet; both have the top type bit set.
    function automatic logic is_pkt_end(input logic [1:0] ftype);
        return ftype[1];
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Per-VC saturating credit counter: starts full, flags a return that arrives while already full.
module noc_credit_counter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_ovf
);

    localparam logic [CW-1:0] MAX = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic          w_up;
    logic          w_down;

    // A simultaneous send and return cancel out and can never overflow.
    always_comb begin
        w_up   = i_inc && !i_dec;
        w_down = i_dec && !i_inc;
        o_ovf  = w_up && (r_count == MAX);
    end

    // Credit count update, saturating at both ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= MAX;
        end else if (w_up && (r_count != MAX)) begin
            r_count <= r_count + CW'(1);
        end else if (w_down && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/noc_local_injector.sv
// PE-side flit injector for one NoC local port with per-VC credit tracking.
// Optional NOC_INJ_STATS_EN adds stat_flits / stat_pkts counters.
module noc_local_injector
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int VC_NUM     = 2,
    parameter int VC_DEPTH   = 4,
    parameter int CW         = $clog2(VC_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FLIT_WIDTH-3:0]       in_data,
    input  logic                        in_last,
    input  logic [$clog2(VC_NUM)-1:0]   in_vc,
    output logic [FLIT_WIDTH-1:0]       local_tx,
    output logic [VC_NUM-1:0]           local_vc_write_tx,
    input  logic [VC_NUM-1:0]           local_incr_rx_vec,
`ifdef NOC_INJ_STATS_EN
    output logic [31:0]                 stat_flits,
    output logic [31:0]                 stat_pkts,
`endif
    output logic                        credit_err
);

    localparam int VW = $clog2(VC_NUM);

    inj_state_e        r_state;
    logic [VW-1:0]     r_cur_vc;
    flit_t             r_tx;
    logic [VC_NUM-1:0] r_vc_write;
    logic              r_credit_err;

    logic [CW-1:0]     w_credit [VC_NUM];
    logic [VC_NUM-1:0] w_dec;
    logic [VC_NUM-1:0] w_ovf;
    logic [VW-1:0]     w_sel_vc;
    logic              w_accept;
    flit_t             w_flit;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_cc
        noc_credit_counter #(.DEPTH(VC_DEPTH), .CW(CW)) u_cc (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_inc   (local_incr_rx_vec[v]),
            .i_dec   (w_dec[v]),
            .o_count (w_credit[v]),
            .o_ovf   (w_ovf[v])
        );
    end

    // The VC is taken from in_vc only on the head word; the ready check uses registered credit.
    always_comb begin
        w_sel_vc = (r_state == ST_BODY) ? r_cur_vc : in_vc;
        in_ready = (w_credit[w_sel_vc] != '0);
        w_accept = in_valid && in_ready;
        w_dec    = '0;
        if (w_accept) begin
            w_dec[w_sel_vc] = 1'b1;
        end else begin
            w_dec = '0;
        end
        w_flit.payload = in_data;
        case (r_state)
            ST_IDLE: w_flit.ftype = in_last ? FLIT_SINGLE : FLIT_HEAD;
            ST_BODY: w_flit.ftype = in_last ? FLIT_TAIL : FLIT_BODY;
            default: w_flit.ftype = FLIT_SINGLE;
        endcase
    end

    // Framing FSM with registered flit, strobe and sticky credit error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cur_vc     <= '0;
            r_tx         <= '0;
            r_vc_write   <= '0;
            r_credit_err <= 1'b0;
        end else begin
            r_vc_write   <= w_dec;
            r_credit_err <= r_credit_err | (|w_ovf);
            if (w_accept) begin
                r_tx <= w_flit;
                case (r_state)
                    ST_IDLE: begin
                        if (!in_last) begin
                            r_state  <= ST_BODY;
                            r_cur_vc <= in_vc;
                        end
                    end
                    ST_BODY: begin
                        if (in_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign local_tx          = r_tx;
    assign local_vc_write_tx = r_vc_write;
    assign credit_err        = r_credit_err;

`ifdef NOC_INJ_STATS_EN
    logic [31:0] r_stat_flits;
    logic [31:0] r_stat_pkts;

    // Traffic counters advance on the same edge that registers the flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_flits <= 32'd0;
            r_stat_pkts  <= 32'd0;
        end else if (w_accept) begin
            r_stat_flits <= r_stat_flits + 32'd1;
            r_stat_pkts  <= r_stat_pkts + {31'd0, is_pkt_end(w_flit.ftype)};
        end
    end

    assign stat_flits = r_stat_flits;
    assign stat_pkts  = r_stat_pkts;
`endif

endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Credit-based flit injector for one local port of the NoC. It accepts packet words from a processing element over a valid/ready stream and frames them into 32-bit flits. It drives the router's local input (flit word plus one-hot VC write strobe) and tracks per-VC credits returned by the router. It is the PE-side transmitter feeding `full_noc` local port inputs. One instance is used per local port.

## Interface
- `FLIT_WIDTH`, default 32: flit width. Bits [31:30] are the flit type, [29:0] the payload.
- `VC_NUM`, default 2: virtual channels per port.
- `VC_DEPTH`, default 4: router input buffer depth per VC, which is the initial credit count.
- `CW`, default `$clog2(VC_DEPTH+1)`: credit counter width.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: packet word valid.
- `in_ready`  out  1: word accepted when `in_valid && in_ready`.
- `in_data`  in  FLIT_WIDTH-2: payload word.
- `in_last`  in  1: last word of the packet.
- `in_vc`  in  $clog2(VC_NUM): target VC; sampled only on the head word.
- `local_tx`  out  FLIT_WIDTH: flit to the router.
- `local_vc_write_tx`  out  VC_NUM: one-hot write strobe qualifying `local_tx`.
- `local_incr_rx_vec`  in  VC_NUM: per-VC credit-return pulse, one credit per cycle per bit.
- `credit_err`  out  1: sticky; set on a credit return while that counter is already at VC_DEPTH.

## Operation
- Flit type encoding:
  - 2'b01: head.
  - 2'b00: body.
  - 2'b10: tail.
  - 2'b11: single-flit packet (head and tail).
- FSM states:
  - IDLE: expects a head word. An accepted word with `in_last=1` sends type 11 and stays in IDLE. Otherwise it sends type 01, latches `in_vc` into `cur_vc`, and moves to BODY.
  - BODY: words use `cur_vc`, and `in_vc` is ignored. `in_last=0` sends type 00. `in_last=1` sends type 10 and returns to IDLE.
- Credits: one counter per VC, reset to VC_DEPTH.
  - A sent flit on VC v decrements `credit[v]`.
  - A `local_incr_rx_vec[v]` pulse increments it.
  - Both in the same cycle leave it unchanged.
  - An increment at VC_DEPTH saturates the counter and sets `credit_err`.
- `in_ready` is 1 when the selected VC has nonzero credit. The selected VC is `in_vc` in IDLE and `cur_vc` in BODY.
- The credit check uses the registered counter value only. A same-cycle return does not enable a send.
- There is no backpressure from the router beyond credits. Every accepted word produces exactly one flit.

## Timing
- Reset values:
  - `local_tx` = 0, `local_vc_write_tx` = 0, `credit_err` = 0.
  - State IDLE, `cur_vc` = 0, all credits = VC_DEPTH.
  - `in_ready` follows from those values: 1 after reset, because credits are VC_DEPTH.
- Latency: a word accepted in cycle N appears as a registered flit on `local_tx` in cycle N+1, with `local_vc_write_tx` one-hot for exactly that cycle. With no accept, the strobe is 0 and `local_tx` holds its value.
- Throughput: one flit per cycle while credit lasts.
- A credit returned in cycle N allows a send in cycle N+1.
- Reset mid-packet: returns to IDLE, drops the partial packet, and restores full credits. The environment resets the router simultaneously.

## Configuration
- `NOC_INJ_STATS_EN`: when defined, two extra outputs are present:
  - `stat_flits` (32b): flits sent.
  - `stat_pkts` (32b): tails plus single-flit packets sent.
  - Both reset to 0, increment in the cycle the flit is registered, and wrap at 2^32.
- Without the macro, these ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Shared package `noc_pkg`:
  - Flit type localparams `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`, `FLIT_SINGLE`.
  - `flit_t` packed struct {type[1:0], payload[29:0]}.
  - FSM state enum.
- One sub-module, `noc_credit_counter`: per-VC saturating up/down counter with an error flag, instantiated VC_NUM times.

## Test plan
- Reset, then single word `in_data`=0x0000_1234, `in_last`=1, `in_vc`=1 -> next cycle `local_tx`=0xC000_1234, `local_vc_write_tx`=2'b10, `credit[1]`=3.
- 3-word packet on VC0 (0xA, 0xB, 0xC), `in_vc` toggled after the head -> flits 0x4000_000A, 0x0000_000B, 0x8000_000C, all with strobe 2'b01; `credit[0]`=1.
- Six single-flit packets on VC0 with no returns -> four flits sent, then `in_ready`=0. One `local_incr_rx_vec[0]` pulse -> `in_ready`=1 next cycle, exactly one more flit sent.
- Credit return on VC0 in the same cycle as a VC0 send at credit 2 -> credit stays 2; no `credit_err`.
- Return pulse on VC1 at credit 4 -> `credit[1]` stays 4, `credit_err`=1 and remains 1 until reset.
- Reset asserted in BODY after 2 flits -> IDLE, credits 4/4, no strobe; the next word is framed as a head.
